// File: rtl/issueque_int_pkg.sv
// Shared definitions for the integer issue queue, dispatch and issue unit:
// opcode encodings, tag/data/opcode widths and the issuability rule.
package issueque_int_pkg;

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd2,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_NOR = 4'd6,
    OP_SLT = 4'd7,
    OP_BEQ = 4'd9
  } opcode_e;

  function automatic logic issuable(input logic valid, input logic rsvalid, input logic rtvalid);
    return valid & rsvalid & rtvalid;
  endfunction

endpackage

// File: rtl/issueque_int_if.sv
// Dispatch, CDB and issue-port signals of the integer issue queue.
interface issueque_int_if
  import issueque_int_pkg::*;
#(
  parameter int unsigned TAGW = TAG_W
);
  logic              flush;
  logic              dispatch_en;
  logic [OP_W-1:0]   dispatch_opcode;
  logic [DATA_W-1:0] dispatch_rsdata;
  logic [DATA_W-1:0] dispatch_rtdata;
  logic [TAGW-1:0]   dispatch_rstag;
  logic [TAGW-1:0]   dispatch_rttag;
  logic              dispatch_rsvalid;
  logic              dispatch_rtvalid;
  logic [TAGW-1:0]   dispatch_rdtag;
  logic              queue_full;
  logic              cdb_valid;
  logic [TAGW-1:0]   cdb_tagout;
  logic [DATA_W-1:0] cdb_out;
  logic              ready_int;
  logic [OP_W-1:0]   opcode;
  logic [DATA_W-1:0] rsdata;
  logic [DATA_W-1:0] rtdata;
  logic [TAGW-1:0]   rdtag;
  logic              issue_int;

  modport master (
    output flush, dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rtdata,
           dispatch_rstag, dispatch_rttag, dispatch_rsvalid, dispatch_rtvalid,
           dispatch_rdtag, cdb_valid, cdb_tagout, cdb_out, issue_int,
    input  queue_full, ready_int, opcode, rsdata, rtdata, rdtag
  );

  modport slave (
    input  flush, dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rtdata,
           dispatch_rstag, dispatch_rttag, dispatch_rsvalid, dispatch_rtvalid,
           dispatch_rdtag, cdb_valid, cdb_tagout, cdb_out, issue_int,
    output queue_full, ready_int, opcode, rsdata, rtdata, rdtag
  );

endinterface

// File: rtl/issueque_entry.sv
// One issue-queue slot: holds an instruction, shifts in from the slot above on
// compaction, loads from dispatch, and snoops the CDB for pending operands.
module issueque_entry
  import issueque_int_pkg::*;
#(
  parameter int unsigned TAGW = TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [OP_W-1:0]   d_opcode_i,
  input  logic [DATA_W-1:0] d_rsdata_i,
  input  logic [TAGW-1:0]   d_rstag_i,
  input  logic              d_rsvalid_i,
  input  logic [DATA_W-1:0] d_rtdata_i,
  input  logic [TAGW-1:0]   d_rttag_i,
  input  logic              d_rtvalid_i,
  input  logic [TAGW-1:0]   d_rdtag_i,
  input  logic              n_valid_i,
  input  logic [OP_W-1:0]   n_opcode_i,
  input  logic [DATA_W-1:0] n_rsdata_i,
  input  logic [TAGW-1:0]   n_rstag_i,
  input  logic              n_rsvalid_i,
  input  logic [DATA_W-1:0] n_rtdata_i,
  input  logic [TAGW-1:0]   n_rttag_i,
  input  logic              n_rtvalid_i,
  input  logic [TAGW-1:0]   n_rdtag_i,
  input  logic              cdb_valid_i,
  input  logic [TAGW-1:0]   cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              valid_o,
  output logic [OP_W-1:0]   opcode_o,
  output logic [DATA_W-1:0] rsdata_o,
  output logic [TAGW-1:0]   rstag_o,
  output logic              rsvalid_o,
  output logic [DATA_W-1:0] rtdata_o,
  output logic [TAGW-1:0]   rttag_o,
  output logic              rtvalid_o,
  output logic [TAGW-1:0]   rdtag_o
);

  logic              valid_q,   valid_d;
  logic [OP_W-1:0]   opcode_q,  opcode_d;
  logic [DATA_W-1:0] rsdata_q,  rsdata_d;
  logic [TAGW-1:0]   rstag_q,   rstag_d;
  logic              rsvalid_q, rsvalid_d;
  logic [DATA_W-1:0] rtdata_q,  rtdata_d;
  logic [TAGW-1:0]   rttag_q,   rttag_d;
  logic              rtvalid_q, rtvalid_d;
  logic [TAGW-1:0]   rdtag_q,   rdtag_d;

  always_comb begin
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    rsdata_d  = rsdata_q;
    rstag_d   = rstag_q;
    rsvalid_d = rsvalid_q;
    rtdata_d  = rtdata_q;
    rttag_d   = rttag_q;
    rtvalid_d = rtvalid_q;
    rdtag_d   = rdtag_q;
    if (load_i) begin
      valid_d   = 1'b1;
      opcode_d  = d_opcode_i;
      rsdata_d  = d_rsdata_i;
      rstag_d   = d_rstag_i;
      rsvalid_d = d_rsvalid_i;
      rtdata_d  = d_rtdata_i;
      rttag_d   = d_rttag_i;
      rtvalid_d = d_rtvalid_i;
      rdtag_d   = d_rdtag_i;
    end else if (shift_i) begin
      valid_d   = n_valid_i;
      opcode_d  = n_opcode_i;
      rsdata_d  = n_rsdata_i;
      rstag_d   = n_rstag_i;
      rsvalid_d = n_rsvalid_i;
      rtdata_d  = n_rtdata_i;
      rttag_d   = n_rttag_i;
      rtvalid_d = n_rtvalid_i;
      rdtag_d   = n_rdtag_i;
    end
    // Snoop after the source mux so shifted and freshly dispatched operands both capture.
    if (valid_d && !rsvalid_d && cdb_valid_i && (rstag_d == cdb_tag_i)) begin
      rsdata_d  = cdb_data_i;
      rsvalid_d = 1'b1;
    end
    if (valid_d && !rtvalid_d && cdb_valid_i && (rttag_d == cdb_tag_i)) begin
      rtdata_d  = cdb_data_i;
      rtvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    opcode_q  <= opcode_d;
    rsdata_q  <= rsdata_d;
    rstag_q   <= rstag_d;
    rsvalid_q <= rsvalid_d;
    rtdata_q  <= rtdata_d;
    rttag_q   <= rttag_d;
    rtvalid_q <= rtvalid_d;
    rdtag_q   <= rdtag_d;
  end

  assign valid_o   = valid_q;
  assign opcode_o  = opcode_q;
  assign rsdata_o  = rsdata_q;
  assign rstag_o   = rstag_q;
  assign rsvalid_o = rsvalid_q;
  assign rtdata_o  = rtdata_q;
  assign rttag_o   = rttag_q;
  assign rtvalid_o = rtvalid_q;
  assign rdtag_o   = rdtag_q;

endmodule

// File: rtl/issueque_int.sv
// Integer issue queue: compacting age-ordered slots, oldest-ready selection,
// one pop and one push per cycle.
module issueque_int
  import issueque_int_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = TAG_W
) (
  input  logic           clk,
  input  logic           reset,
  issueque_int_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Slot DEPTH is a permanently empty tie-off so the top slot shifts in "invalid".
  logic [DEPTH:0]    e_valid;
  logic [DEPTH:0]    e_rsv;
  logic [DEPTH:0]    e_rtv;
  logic [OP_W-1:0]   e_op    [DEPTH+1];
  logic [DATA_W-1:0] e_rs    [DEPTH+1];
  logic [DATA_W-1:0] e_rt    [DEPTH+1];
  logic [TAGW-1:0]   e_rstag [DEPTH+1];
  logic [TAGW-1:0]   e_rttag [DEPTH+1];
  logic [TAGW-1:0]   e_rd    [DEPTH+1];

  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     sel_idx;
  logic [CW-1:0]     slot;
  logic              sel_found;
  logic              pop, push, full;
  logic [DEPTH-1:0]  load, shift;

  assign e_valid[DEPTH] = 1'b0;
  assign e_rsv[DEPTH]   = 1'b0;
  assign e_rtv[DEPTH]   = 1'b0;
  assign e_op[DEPTH]    = '0;
  assign e_rs[DEPTH]    = '0;
  assign e_rt[DEPTH]    = '0;
  assign e_rstag[DEPTH] = '0;
  assign e_rttag[DEPTH] = '0;
  assign e_rd[DEPTH]    = '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    issueque_entry #(.TAGW(TAGW)) u_ent (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (bus.flush),
      .load_i      (load[g]),
      .shift_i     (shift[g]),
      .d_opcode_i  (bus.dispatch_opcode),
      .d_rsdata_i  (bus.dispatch_rsdata),
      .d_rstag_i   (bus.dispatch_rstag),
      .d_rsvalid_i (bus.dispatch_rsvalid),
      .d_rtdata_i  (bus.dispatch_rtdata),
      .d_rttag_i   (bus.dispatch_rttag),
      .d_rtvalid_i (bus.dispatch_rtvalid),
      .d_rdtag_i   (bus.dispatch_rdtag),
      .n_valid_i   (e_valid[g+1]),
      .n_opcode_i  (e_op[g+1]),
      .n_rsdata_i  (e_rs[g+1]),
      .n_rstag_i   (e_rstag[g+1]),
      .n_rsvalid_i (e_rsv[g+1]),
      .n_rtdata_i  (e_rt[g+1]),
      .n_rttag_i   (e_rttag[g+1]),
      .n_rtvalid_i (e_rtv[g+1]),
      .n_rdtag_i   (e_rd[g+1]),
      .cdb_valid_i (bus.cdb_valid),
      .cdb_tag_i   (bus.cdb_tagout),
      .cdb_data_i  (bus.cdb_out),
      .valid_o     (e_valid[g]),
      .opcode_o    (e_op[g]),
      .rsdata_o    (e_rs[g]),
      .rstag_o     (e_rstag[g]),
      .rsvalid_o   (e_rsv[g]),
      .rtdata_o    (e_rt[g]),
      .rttag_o     (e_rttag[g]),
      .rtvalid_o   (e_rtv[g]),
      .rdtag_o     (e_rd[g])
    );
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && issuable(e_valid[i], e_rsv[i], e_rtv[i])) begin
        sel_found = 1'b1;
        sel_idx   = CW'(i);
      end
    end
  end

  always_comb begin
    bus.ready_int  = sel_found;
    bus.opcode     = sel_found ? e_op[sel_idx] : '0;
    bus.rsdata     = sel_found ? e_rs[sel_idx] : '0;
    bus.rtdata     = sel_found ? e_rt[sel_idx] : '0;
    bus.rdtag      = sel_found ? e_rd[sel_idx] : '0;
    bus.queue_full = full;
  end

  // Push slot is computed after the pop shift; load beats shift in the same slot.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    pop     = bus.issue_int & sel_found;
    push    = bus.dispatch_en & ~full;
    slot    = count_q - CW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    load    = '0;
    shift   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      load[i]  = push && (slot == CW'(i));
      shift[i] = pop && (CW'(i) >= sel_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || bus.flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
